// File: rtl/ce_strobe_gen.sv
// Programmable clock-enable strobe generator: after start, one-cycle clock_enable
// pulse every div cycles, continuously or for a burst of burst_len pulses.
module ce_strobe_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst_len,
  output logic             clock_enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  // State bits double as the busy/done output flops.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase;
  logic [CNT_W-1:0] burst_q;
  logic [DIV_W-1:0] div_eff;
  logic [CNT_W-1:0] count_inc;
  logic             launch;
  logic             last_strobe;

  assign div_eff     = (div == '0) ? DIV_W'(1) : div;
  assign launch      = (state == S_IDLE) && start && !stop;
  assign count_inc   = pulse_count + 1'b1;
  assign last_strobe = (burst_q != '0) && (count_inc == burst_q);

  assign busy = state[0];
  assign done = state[1];

  // Run parameters are pure data: captured at launch, no reset needed.
  always_ff @(posedge clk) begin
    if (launch) begin
      div_q   <= div_eff;
      burst_q <= burst_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      clock_enable <= 1'b0;
      phase        <= '0;
      pulse_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          clock_enable <= 1'b0;
          if (launch) begin
            state       <= S_RUN;
            pulse_count <= '0;
            phase       <= div_eff - 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Abort wins over a strobe due on this same edge.
            state        <= S_IDLE;
            clock_enable <= 1'b0;
          end else if (phase == '0) begin
            clock_enable <= 1'b1;
            phase        <= div_q - 1'b1;
            pulse_count  <= count_inc;
            if (last_strobe) state <= S_DONE;
          end else begin
            clock_enable <= 1'b0;
            phase        <= phase - 1'b1;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          clock_enable <= 1'b0;
        end
        default: begin
          state        <= S_IDLE;
          clock_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ce_strobe_gen.sv
// Self-checking bench for ce_strobe_gen: vector table of runs scored cycle by cycle
// against a closed-form strobe schedule, plus hand-written corner sequences.
module tb_ce_strobe_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] div = 8'd0;
  logic [7:0] burst_len = 8'd0;
  logic       clock_enable;
  logic       busy;
  logic       done;
  logic [7:0] pulse_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ce_strobe_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .div          (div),
    .burst_len    (burst_len),
    .clock_enable (clock_enable),
    .busy         (busy),
    .done         (done),
    .pulse_count  (pulse_count)
  );

  // Downstream enabled flop driven by the strobe
  logic ff_d = 1'b0;
  logic ff_q = 1'b0;
  always_ff @(posedge clk) if (clock_enable) ff_q <= ff_d;

  typedef struct packed {
    logic       ce;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    int div_in;
    int blen;
    int stop_at;
    int ncyc;
    int exp_cnt;
    int exp_done;
  } vec_t;

  obs_t exp_q[$];
  vec_t vecs[8];

  // Expected outputs in cycle n after the start edge (n=0 is the cycle right after it).
  function automatic obs_t model(int d, int b, int stop_at, int n);
    obs_t o;
    int   last;
    int   m;
    bit   stopped;
    last    = b * d;
    stopped = (stop_at != 0) && ((b == 0) || (stop_at <= last)) && (n >= stop_at);
    if (stopped) begin
      m = (stop_at - 1) / d;
      o.ce = 1'b0; o.busy = 1'b0; o.done = 1'b0;
    end else if ((b != 0) && (n >= last)) begin
      m = b;
      o.ce = (n == last); o.busy = 1'b0; o.done = (n == last);
    end else begin
      m = n / d;
      o.ce = (n > 0) && (n % d == 0); o.busy = 1'b1; o.done = 1'b0;
    end
    o.cnt = 8'(m);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got ce=%0b busy=%0b done=%0b cnt=%0d, expected ce=%0b busy=%0b done=%0b cnt=%0d",
               nm, got.ce, got.busy, got.done, got.cnt, want.ce, want.busy, want.done, want.cnt);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Push expectation at drive time, take one clock, pop and compare against the DUT.
  task automatic step_check(input string nm, input obs_t e);
    obs_t got;
    obs_t want;
    exp_q.push_back(e);
    tick();
    got  = {clock_enable, busy, done, pulse_count};
    want = exp_q.pop_front();
    check(nm, got, want);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d;
    int done_seen;
    d = (v.div_in == 0) ? 1 : v.div_in;
    done_seen = 0;
    div       = 8'(v.div_in);
    burst_len = 8'(v.blen);
    start     = 1'b1;
    for (int n = 0; n < v.ncyc; n++) begin
      stop = (v.stop_at != 0) && (n >= v.stop_at);
      step_check($sformatf("vec%0d_cyc%0d", idx, n), model(d, v.blen, v.stop_at, n));
      start = 1'b0;
      if (done) done_seen++;
    end
    stop = 1'b0;
    check_int($sformatf("vec%0d_final_count", idx), int'(pulse_count), v.exp_cnt);
    check_int($sformatf("vec%0d_done_pulses", idx), done_seen, v.exp_done);
  endtask

  initial begin
    obs_t zero;
    logic prev_ce;
    logic prev_d;
    logic exp_ff;
    zero = '0;

    vecs[0] = '{4,   3, 0,   15,  3, 1};
    vecs[1] = '{1,   0, 11,  14,  10, 0};
    vecs[2] = '{0,   2, 0,   5,   2, 1};
    vecs[3] = '{3,   0, 8,   10,  2, 0};
    vecs[4] = '{2,   4, 5,   8,   2, 0};
    vecs[5] = '{5,   0, 5,   7,   0, 0};
    vecs[6] = '{1,   0, 258, 260, 1, 0};
    vecs[7] = '{255, 1, 0,   258, 1, 1};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {clock_enable, busy, done, pulse_count}, zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted between edges while strobing
    div = 8'd1; burst_len = 8'd0; start = 1'b1;
    step_check("rst_run_c0", model(1, 0, 0, 0));
    start = 1'b0;
    step_check("rst_run_c1", model(1, 0, 0, 1));
    step_check("rst_run_c2", model(1, 0, 0, 2));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {clock_enable, busy, done, pulse_count}, zero);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1; div = 8'd3; burst_len = 8'd0;
    for (int n = 0; n < 3; n++)
      step_check($sformatf("start_stop_idle%0d", n), obs_t'({3'b000, 8'd1}));
    // start re-asserted throughout RUN and div changed mid-run: period stays 3
    stop = 1'b0;
    step_check("restart_c0", model(3, 0, 0, 0));
    div = 8'd7;
    for (int n = 1; n <= 10; n++)
      step_check($sformatf("restart_c%0d", n), model(3, 0, 0, n));
    start = 1'b0; stop = 1'b1;
    step_check("restart_stop", model(3, 0, 11, 11));
    stop = 1'b0;

    // start held high across a burst: DONE -> one IDLE cycle -> RUN again
    div = 8'd2; burst_len = 8'd2; start = 1'b1;
    for (int n = 0; n <= 4; n++)
      step_check($sformatf("held_c%0d", n), model(2, 2, 0, n));
    step_check("held_idle_gap", obs_t'({3'b000, 8'd2}));
    step_check("held_rerun_c0", model(2, 2, 0, 0));
    step_check("held_rerun_c1", model(2, 2, 0, 1));
    start = 1'b0;
    for (int n = 2; n <= 5; n++)
      step_check($sformatf("held_rerun_c%0d", n), model(2, 2, 0, n));

    // Enabled flop downstream, div=3: q follows d only after strobe cycles
    div = 8'd3; burst_len = 8'd0; start = 1'b1;
    exp_ff = ff_q;
    for (int n = 0; n < 13; n++) begin
      prev_ce = clock_enable;
      prev_d  = ff_d;
      tick();
      start = 1'b0;
      if (prev_ce) exp_ff = prev_d;
      n_tests++;
      if (ff_q !== exp_ff) begin
        n_fail++;
        $display("FAIL ff_chain_c%0d: got q=%0b, expected q=%0b", n, ff_q, exp_ff);
      end
      ff_d = ~ff_d;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_int("ff_chain_count", int'(pulse_count), 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
